// File: rtl/l2_ram_bank_init_pkg.sv
// Shared types for the L2 RAM bank init/check controller.
package l2_ram_bank_init_pkg;

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} init_state_e;

  typedef enum logic {MODE_CLEAR, MODE_CHECK} init_mode_e;

  // A single-word bank still needs a 1-bit address.
  function automatic int unsigned addr_width(input int unsigned num_words);
    return (num_words > 1) ? $clog2(num_words) : 1;
  endfunction

endpackage

// File: rtl/l2_ram_bank_err_log.sv
// Mismatch logger: sticky error flag, saturating count, first failing address.
module l2_ram_bank_err_log #(
  parameter int unsigned AddrWidth   = 10,
  parameter int unsigned ErrCntWidth = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   cmp_valid_i,
  input  logic                   mismatch_i,
  input  logic [AddrWidth-1:0]   cmp_addr_i,
  output logic                   error_o,
  output logic [ErrCntWidth-1:0] err_cnt_o,
  output logic [AddrWidth-1:0]   first_err_addr_o
);

  logic                   error_q, error_d;
  logic [ErrCntWidth-1:0] cnt_q, cnt_d;
  logic [AddrWidth-1:0]   first_q, first_d;

  always_comb begin
    error_d = error_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    if (clear_i) begin
      error_d = 1'b0;
      cnt_d   = '0;
      first_d = '0;
    end else if (cmp_valid_i && mismatch_i) begin
      error_d = 1'b1;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + ErrCntWidth'(1);
      end
      if (!error_q) begin
        first_d = cmp_addr_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      error_q <= 1'b0;
      cnt_q   <= '0;
      first_q <= '0;
    end else begin
      error_q <= error_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  assign error_o          = error_q;
  assign err_cnt_o        = cnt_q;
  assign first_err_addr_o = first_q;

endmodule

// File: rtl/l2_ram_bank_init_ctrl.sv
// Bank initialiser: owns the bank port while sweeping a fill (and optional readback check),
// otherwise passes the functional port straight through.
module l2_ram_bank_init_ctrl
  import l2_ram_bank_init_pkg::*;
#(
  parameter int unsigned NumWords    = 1024,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned AddrXor     = 0,
  parameter int unsigned ErrCntWidth = 16,
  localparam int unsigned AddrWidth  = addr_width(NumWords),
  localparam int unsigned BeWidth    = (DataWidth + 7) / 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   check_i,
  input  logic [DataWidth-1:0]   pattern_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic [ErrCntWidth-1:0] err_cnt_o,
  output logic [AddrWidth-1:0]   first_err_addr_o,
  input  logic                   fn_req_i,
  input  logic                   fn_we_i,
  input  logic [AddrWidth-1:0]   fn_addr_i,
  input  logic [DataWidth-1:0]   fn_wdata_i,
  input  logic [BeWidth-1:0]     fn_be_i,
  output logic                   fn_gnt_o,
  output logic [DataWidth-1:0]   fn_rdata_o,
  output logic                   bank_req_o,
  output logic                   bank_we_o,
  output logic [AddrWidth-1:0]   bank_addr_o,
  output logic [DataWidth-1:0]   bank_wdata_o,
  output logic [BeWidth-1:0]     bank_be_o,
  input  logic [DataWidth-1:0]   bank_rdata_i
);

  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 1);

  init_state_e          state_q, state_d;
  init_mode_e           mode_q, mode_d;
  logic [DataWidth-1:0] pattern_q, pattern_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 cmp_valid_q, cmp_valid_d;
  logic [AddrWidth-1:0] cmp_addr_q, cmp_addr_d;
  logic                 start_accept;
  logic                 mismatch;

  function automatic logic [DataWidth-1:0] word_for(input logic [DataWidth-1:0] pat,
                                                    input logic [AddrWidth-1:0] a);
    logic [DataWidth-1:0] w;
    w = pat;
    if (AddrXor != 0) begin
      w = pat ^ DataWidth'(a);
    end
    return w;
  endfunction

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    pattern_d    = pattern_q;
    addr_d       = addr_q;
    cmp_valid_d  = 1'b0;
    cmp_addr_d   = cmp_addr_q;
    start_accept = 1'b0;
    bank_req_o   = 1'b0;
    bank_we_o    = 1'b0;
    bank_addr_o  = '0;
    bank_wdata_o = '0;
    bank_be_o    = '0;

    unique case (state_q)
      IDLE: begin
        bank_req_o   = fn_req_i;
        bank_we_o    = fn_we_i;
        bank_addr_o  = fn_addr_i;
        bank_wdata_o = fn_wdata_i;
        bank_be_o    = fn_be_i;
        if (start_i) begin
          start_accept = 1'b1;
          mode_d       = check_i ? MODE_CHECK : MODE_CLEAR;
          pattern_d    = pattern_i;
          addr_d       = '0;
          state_d      = WRITE;
        end
      end
      WRITE: begin
        bank_req_o   = 1'b1;
        bank_we_o    = 1'b1;
        bank_addr_o  = addr_q;
        bank_wdata_o = word_for(pattern_q, addr_q);
        bank_be_o    = '1;
        if (addr_q == LastAddr) begin
          addr_d  = '0;
          state_d = (mode_q == MODE_CHECK) ? READ : DONE;
        end else begin
          addr_d = addr_q + AddrWidth'(1);
        end
      end
      READ: begin
        bank_req_o  = 1'b1;
        bank_addr_o = addr_q;
        bank_be_o   = '1;
        cmp_valid_d = 1'b1;
        cmp_addr_d  = addr_q;
        if (addr_q == LastAddr) begin
          addr_d  = '0;
          state_d = DRAIN;
        end else begin
          addr_d = addr_q + AddrWidth'(1);
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      mode_q      <= MODE_CLEAR;
      pattern_q   <= '0;
      addr_q      <= '0;
      cmp_valid_q <= 1'b0;
      cmp_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      pattern_q   <= pattern_d;
      addr_q      <= addr_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_addr_q  <= cmp_addr_d;
    end
  end

  // Read data for the word issued last cycle arrives now.
  assign mismatch = cmp_valid_q && (bank_rdata_i != word_for(pattern_q, cmp_addr_q));

  l2_ram_bank_err_log #(
    .AddrWidth  (AddrWidth),
    .ErrCntWidth(ErrCntWidth)
  ) u_err_log (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .clear_i         (start_accept),
    .cmp_valid_i     (cmp_valid_q),
    .mismatch_i      (mismatch),
    .cmp_addr_i      (cmp_addr_q),
    .error_o         (error_o),
    .err_cnt_o       (err_cnt_o),
    .first_err_addr_o(first_err_addr_o)
  );

  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);
  assign fn_gnt_o   = (state_q == IDLE);
  assign fn_rdata_o = bank_rdata_i;

endmodule

// File: tb/tb_l2_ram_bank_init_ctrl.sv
// Bench: two controllers (AddrXor 0 and 1) on behavioural banks, checked every cycle
// against a sweep-timeline model plus directed literal expectations.
module tb_l2_ram_bank_init_ctrl;

  localparam int NW = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, check, fn_req, fn_we;
  logic [31:0] pattern, fn_wdata;
  logic [3:0]  fn_addr, fn_be;
  logic        flip_en;
  logic [15:0] flip_mask;

  logic        busy [2], done [2], error [2], gnt [2], b_req [2], b_we [2];
  logic [2:0]  err_cnt [2];
  logic [3:0]  first [2], b_addr [2], b_be [2];
  logic [31:0] fn_rdata [2], b_wdata [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gen_bank
    logic [31:0] mem [NW];
    logic [31:0] rdata_q;

    l2_ram_bank_init_ctrl #(
      .NumWords   (NW),
      .DataWidth  (32),
      .AddrXor    (g),
      .ErrCntWidth(3)
    ) u_dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .start_i         (start),
      .check_i         (check),
      .pattern_i       (pattern),
      .busy_o          (busy[g]),
      .done_o          (done[g]),
      .error_o         (error[g]),
      .err_cnt_o       (err_cnt[g]),
      .first_err_addr_o(first[g]),
      .fn_req_i        (fn_req),
      .fn_we_i         (fn_we),
      .fn_addr_i       (fn_addr),
      .fn_wdata_i      (fn_wdata),
      .fn_be_i         (fn_be),
      .fn_gnt_o        (gnt[g]),
      .fn_rdata_o      (fn_rdata[g]),
      .bank_req_o      (b_req[g]),
      .bank_we_o       (b_we[g]),
      .bank_addr_o     (b_addr[g]),
      .bank_wdata_o    (b_wdata[g]),
      .bank_be_o       (b_be[g]),
      .bank_rdata_i    (rdata_q)
    );

    // Fault injection flips bit 0 of read data at the masked addresses.
    always @(posedge clk) begin
      if (b_req[g]) begin
        if (b_we[g]) begin
          for (int k = 0; k < 4; k++) begin
            if (b_be[g][k]) mem[b_addr[g]][k*8 +: 8] <= b_wdata[g][k*8 +: 8];
          end
        end else begin
          rdata_q <= mem[b_addr[g]] ^ {31'd0, flip_en & flip_mask[b_addr[g]]};
        end
      end
    end
  end

  task automatic chk(input string nm, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d: got %h expected %h at %0t", nm, inst, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] expw(input int inst, input logic [31:0] pat, input int a);
    return (inst == 1) ? (pat ^ 32'(a)) : pat;
  endfunction

  // Model: a sweep is a timeline t = 0..len-1 after the accepted start.
  bit          m_act, m_chk, m_err, m_pend, m_pend_mis, rd_pend;
  int          m_t, m_len, m_cnt, m_first, m_pend_a;
  logic [31:0] m_pat;
  logic [31:0] rd_exp [2];
  logic [31:0] m_mem [2][NW];

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_act = 0; m_err = 0; m_cnt = 0; m_first = 0; m_pend = 0; rd_pend = 0;
      end
      for (int i = 0; i < 2; i++) begin
        chk("busy", i, busy[i], m_act);
        chk("done", i, done[i], m_act && (m_t == m_len - 1));
        chk("fn_gnt", i, gnt[i], !m_act);
        chk("error", i, error[i], m_err);
        chk("err_cnt", i, err_cnt[i], m_cnt);
        chk("first_err_addr", i, first[i], m_first);
        if (!m_act) begin
          chk("bank_req_pass", i, b_req[i], fn_req);
          if (fn_req) begin
            chk("bank_we_pass", i, b_we[i], fn_we);
            chk("bank_addr_pass", i, b_addr[i], fn_addr);
            chk("bank_wdata_pass", i, b_wdata[i], fn_wdata);
            chk("bank_be_pass", i, b_be[i], fn_be);
          end
        end else if (m_t < NW) begin
          chk("wr_req", i, {b_req[i], b_we[i]}, 2'b11);
          chk("wr_addr", i, b_addr[i], m_t);
          chk("wr_data", i, b_wdata[i], expw(i, m_pat, m_t));
          chk("wr_be", i, b_be[i], 4'hF);
        end else if (m_chk && m_t < 2 * NW) begin
          chk("rd_req", i, {b_req[i], b_we[i]}, 2'b10);
          chk("rd_addr", i, b_addr[i], m_t - NW);
        end else begin
          chk("idle_req", i, b_req[i], 1'b0);
        end
        if (rd_pend) chk("fn_rdata", i, fn_rdata[i], rd_exp[i]);
      end
      if (rst_n) begin
        if (m_pend && m_pend_mis) begin
          if (!m_err) m_first = m_pend_a;
          m_err = 1;
          m_cnt = (m_cnt < 7) ? m_cnt + 1 : 7;
        end
        m_pend  = 0;
        rd_pend = 0;
        if (!m_act && fn_req) begin
          for (int i = 0; i < 2; i++) begin
            if (fn_we) begin
              for (int k = 0; k < 4; k++)
                if (fn_be[k]) m_mem[i][fn_addr][k*8 +: 8] = fn_wdata[k*8 +: 8];
            end else begin
              rd_exp[i] = m_mem[i][fn_addr] ^ {31'd0, flip_en & flip_mask[fn_addr]};
            end
          end
          rd_pend = !fn_we;
        end
        if (m_act) begin
          if (m_t < NW) begin
            for (int i = 0; i < 2; i++) m_mem[i][m_t] = expw(i, m_pat, m_t);
          end else if (m_chk && m_t < 2 * NW) begin
            m_pend     = 1;
            m_pend_a   = m_t - NW;
            m_pend_mis = (m_mem[0][m_pend_a] ^ {31'd0, flip_en & flip_mask[m_pend_a]})
                         !== expw(0, m_pat, m_pend_a);
          end
          m_t++;
          if (m_t == m_len) m_act = 0;
        end else if (start) begin
          m_act = 1; m_t = 0; m_chk = check; m_pat = pattern;
          m_len = check ? 2 * NW + 2 : NW + 1;
          m_err = 0; m_cnt = 0; m_first = 0;
        end
      end
    end
  end

  // Entered and left at posedge+1; returns the number of busy cycles observed.
  task automatic sweep(input bit md, input logic [31:0] pat, input bit hold_fn,
                       input int restart_at, output int n);
    bit ended;
    n = 0;
    ended = 0;
    start = 1; check = md; pattern = pat;
    @(posedge clk); #1;
    start = 0; fn_we = 0; fn_req = hold_fn;
    if (hold_fn) fn_addr = 4'd2;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!busy[0]) begin
        ended = 1;
        break;
      end
      n++;
      @(posedge clk); #1;
      start = (n == restart_at);
    end
    if (!ended) chk("sweep_timeout", 0, 1, 0);
    if (hold_fn) chk("gnt_after_done", 0, gnt[0], 1'b1);
    @(posedge clk); #1;
    start = 0; fn_req = 0;
  endtask

  task automatic fn_read(input logic [3:0] a, output logic [31:0] d0, output logic [31:0] d1);
    fn_req = 1; fn_we = 0; fn_addr = a;
    @(posedge clk); #1;
    fn_req = 0;
    @(negedge clk);
    d0 = fn_rdata[0];
    d1 = fn_rdata[1];
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    logic [31:0] d0, d1;
    bit md;
    rst_n = 0; start = 0; check = 0; pattern = 0; fn_req = 0; fn_we = 0;
    fn_addr = 0; fn_wdata = 0; fn_be = 0; flip_en = 0; flip_mask = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;

    sweep(0, 32'hA5A5A5A5, 0, -1, n);
    chk("clear_busy_len", 0, n, 17);
    fn_read(4'd0, d0, d1);
    chk("clear_rd0", 0, d0, 32'hA5A5A5A5);
    fn_read(4'd15, d0, d1);
    chk("clear_rd15", 0, d0, 32'hA5A5A5A5);
    chk("clear_rd15", 1, d1, 32'hA5A5A5AA);

    sweep(1, 32'h0, 0, -1, n);
    chk("check_busy_len", 0, n, 34);
    chk("check_error", 1, error[1], 1'b0);
    chk("check_cnt", 1, err_cnt[1], 3'd0);
    fn_read(4'd7, d0, d1);
    chk("check_word7", 1, d1, 32'h7);

    flip_mask = 16'h0220; flip_en = 1;
    sweep(1, 32'hDEADBEEF, 0, -1, n);
    flip_en = 0;
    for (int i = 0; i < 2; i++) begin
      chk("flip_error", i, error[i], 1'b1);
      chk("flip_cnt", i, err_cnt[i], 3'd2);
      chk("flip_first", i, first[i], 4'd5);
    end

    sweep(0, 32'h0F0F1234, 1, 4, n);
    chk("stall_busy_len", 0, n, 17);
    @(negedge clk);
    chk("stall_rdata", 0, fn_rdata[0], 32'h0F0F1234);
    chk("stall_rdata", 1, fn_rdata[1], 32'h0F0F1236);
    @(posedge clk); #1;

    fn_req = 1; fn_we = 1; fn_addr = 4'd3; fn_wdata = 32'h1234; fn_be = 4'hF;
    sweep(0, 32'h5A5A0000, 0, -1, n);
    fn_read(4'd3, d0, d1);
    chk("overwrite_a3", 0, d0, 32'h5A5A0000);
    chk("overwrite_a3", 1, d1, 32'h5A5A0003);

    start = 1; check = 1; pattern = 32'h3C3C3C3C;
    @(posedge clk); #1;
    start = 0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    rst_n = 0;
    @(negedge clk);
    chk("rst_busy", 0, busy[0], 1'b0);
    chk("rst_status", 0, {done[0], error[0], err_cnt[0], first[0]}, 9'd0);
    chk("rst_bank_req", 0, b_req[0], 1'b0);
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    sweep(1, 32'h3C3C3C3C, 0, -1, n);
    chk("post_rst_len", 0, n, 34);
    chk("post_rst_error", 0, error[0], 1'b0);

    for (int r = 0; r < 12; r++) begin
      repeat ($urandom_range(0, 4)) begin
        fn_req = 1'($urandom); fn_we = 1'($urandom); fn_addr = 4'($urandom);
        fn_wdata = $urandom; fn_be = 4'($urandom);
        @(posedge clk); #1;
      end
      fn_req = 0;
      md = (r == 11) ? 1'b1 : 1'($urandom);
      flip_mask = (r == 11) ? 16'hFFFF : 16'($urandom & $urandom);
      flip_en = 1;
      sweep(md, $urandom, 1'($urandom), ($urandom_range(0, 2) == 0) ? $urandom_range(1, 10) : -1,
            n);
      flip_en = 0;
      chk("rand_busy_len", 0, n, md ? 34 : 17);
    end
    chk("sat_cnt", 0, err_cnt[0], 3'd7);
    chk("sat_first", 0, first[0], 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
